hash_nway_bucket: RTL and testbench
===================================

Name: hash_nway_bucket

Overview:
- N-way set-associative MAC address table for the switch forwarding path, replacing the fixed 2-way bucket.
- Each hash index selects one set of WAYS entries. One shared search port serves source-MAC learning and destination-MAC lookup.
- A background aging walk decrements live counters and invalidates expired entries.
- Storage is one behavioural single-port synchronous RAM per way, with 1-cycle read latency, held inside the block.

Parameters:
WAYS, 4, number of ways per set (2..8)
ADDR_W, 10, hash index width; set count = 2**ADDR_W
PORT_W, 16, portmap width
AGE_W, 10, live counter width
LIVE_TH, 150, live value written on learn or refresh (must fit AGE_W)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
se_source  in  1  1 = learn (source MAC), 0 = lookup (destination MAC)
se_mac  in  48  MAC to learn or look up
se_portmap  in  PORT_W  portmap stored on learn
se_hash  in  ADDR_W  set index
se_req  in  1  search request level; held until se_ack or se_nak
se_ack  out  1  1-cycle pulse: success
se_nak  out  1  1-cycle pulse: failure (lookup miss, or learn with set full)
se_result  out  PORT_W  lookup portmap; valid while se_ack is high on a lookup, holds value otherwise
aging_req  in  1  request one aging step
aging_ack  out  1  1-cycle pulse when the aging walk wraps from the last set to set 0
init_done  out  1  high once the post-reset clear has completed

Behaviour:
- Entry layout, MSB first: valid(1), age(AGE_W), mac(48), portmap(PORT_W). Entry width = 1+AGE_W+48+PORT_W.
- Reset values:
  - se_ack, se_nak, aging_ack, init_done = 0; se_result = 0.
  - Aging pointer = 0; state = CLEAR.
  - Reset asserted mid-operation aborts the operation with no ack/nak and restarts CLEAR.
- States: CLEAR, IDLE, RD, WAIT, CMP, ACT, AG_WAIT, AG_CMP, AG_WR, DONE.
- CLEAR:
  - Writes all-zero to address 0..2**ADDR_W-1 of every way, one address per cycle.
  - After the last address: init_done = 1, go to IDLE.
  - se_req and aging_req are ignored (never acked) during CLEAR.
- IDLE priority is se_req over aging_req.
  - On se_req: latch se_mac, se_portmap, se_source, se_hash; drive all way addresses = se_hash; go to RD.
  - On aging_req: drive addresses = aging pointer, then advance it. If the pointer was 2**ADDR_W-1 it wraps to 0 and aging_ack pulses in the next cycle. Go to AG_WAIT.
- RD -> WAIT -> CMP: RAM data is registered, giving per-way hit[w] = valid & (mac == latched MAC).
- ACT, lookup:
  - Any hit: se_ack = 1 and se_result = portmap of the lowest-index hit way.
  - No hit: se_nak = 1.
- ACT, learn:
  - Any hit: rewrite the lowest hit way with {1, LIVE_TH, mac, new portmap}; se_ack. This refreshes both age and portmap.
  - Else if any invalid way: write the new entry to the lowest-index invalid way; se_ack.
  - Else (set full): se_nak, no write. The optional feature changes this case.
- ACT -> DONE -> IDLE. se_ack/se_nak is visible in the 5th cycle after the accepted se_req cycle (accept cycle = 0). The requester drops se_req on ack/nak; a request still high in IDLE is treated as a new request.
- Aging, per way, in AG_WR:
  - Valid and age > 0: write age-1, other fields unchanged.
  - Valid and age == 0: write all-zero (entry invalidated).
  - Invalid: write all-zero.
  - Then DONE -> IDLE.
- Duplicate hits (same MAC valid in more than one way) cannot arise from this block's own learning. If present, the lowest way wins for both lookup and refresh.
- Age arithmetic is unsigned AGE_W bits and never underflows.

Optional Feature:
HASH_EVICT_OLDEST_EN
- Defined: a learn that finds the set full and no hit overwrites the valid way with the smallest age (ties go to the lowest index) and returns se_ack instead of se_nak. The comparison is a combinational min-tree over WAYS ages in CMP, registered into ACT.
- Undefined: a full set returns se_nak with no write. No min-tree logic is present.

Test Plan:
- Reset, then count cycles to init_done=1 -> exactly 2**ADDR_W cycles of CLEAR; every entry reads back zero; se_req issued during CLEAR gets no ack until after init_done.
- Learn mac 0x0011_2233_4455, portmap 0x0004, hash 0x05A -> se_ack in cycle 5. Lookup of the same mac/hash -> se_ack, se_result = 0x0004. Lookup of mac 0x0011_2233_4456 -> se_nak.
- Learn the same mac again with portmap 0x0010 -> same way rewritten, age = 150; lookup returns 0x0010; no second way consumed.
- Learn 5 distinct MACs to hash 0x3FF with WAYS=4 -> first 4 ack into ways 0..3. Fifth: se_nak without the macro; with the macro, se_ack and it replaces the way with the smallest age (preset way 2 oldest by prior aging).
- LIVE_TH=2: learn one entry, then issue aging passes over all sets, observing aging_ack once per 2**ADDR_W steps -> entry still found after 2 passes, se_nak after the 3rd.
- Assert se_req and aging_req in the same IDLE cycle -> search serviced first, aging step follows. Reset asserted during ACT -> no ack/nak, re-enters CLEAR, init_done drops to 0.

Source files
------------

// File: rtl/hash_nway_bucket.sv
// WAYS-way set-associative MAC table: shared learn/lookup search port plus a background aging walk.
// Build option HASH_EVICT_OLDEST_EN: a learn into a full set evicts the valid way with the smallest age.
module hash_nway_bucket #(
  parameter int WAYS    = 4,
  parameter int ADDR_W  = 10,
  parameter int PORT_W  = 16,
  parameter int AGE_W   = 10,
  parameter int LIVE_TH = 150
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              se_source,
  input  logic [47:0]       se_mac,
  input  logic [PORT_W-1:0] se_portmap,
  input  logic [ADDR_W-1:0] se_hash,
  input  logic              se_req,
  output logic              se_ack,
  output logic              se_nak,
  output logic [PORT_W-1:0] se_result,
  input  logic              aging_req,
  output logic              aging_ack,
  output logic              init_done
);
  localparam int EW     = 1 + AGE_W + 48 + PORT_W;
  localparam int DEPTH  = 2**ADDR_W;
  localparam int WIX    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int MAC_LO = PORT_W;
  localparam int MAC_HI = PORT_W + 47;
  localparam int AGE_LO = PORT_W + 48;
  localparam int AGE_HI = PORT_W + 48 + AGE_W - 1;

  // state   | meaning
  // CLEAR   | zero one address of every way per cycle | IDLE | arbitrate search over aging
  // RD/WAIT | RAM read, data then hit registered      | CMP  | pick way | ACT | write + ack/nak
  // AG_*    | aging read, decrement, write back       | DONE | one settle cycle
  typedef enum logic [3:0] {CLEAR, IDLE, RD, WAIT, CMP, ACT, AG_WAIT, AG_CMP, AG_WR, DONE} state_t;

  state_t                     state_q;
  logic [ADDR_W-1:0]          clr_q, age_ptr_q, addr_q;
  logic [47:0]                mac_q;
  logic [PORT_W-1:0]          pm_q, res_q, res_d;
  logic                       src_q, act_ok_q, act_ok_d;
  logic [WAYS-1:0]            hit_q, hit_d, act_we_q, act_we_d;
  logic [WAYS-1:0][EW-1:0]    ram_q, rd_q, ag_wd_q, ag_wd_d, ram_wd;
  logic [WAYS-1:0]            ram_we;
  logic [ADDR_W-1:0]          ram_addr;
  logic [EW-1:0]              mem [WAYS][DEPTH];
  logic                       hit_any, inv_any;
  logic [WIX-1:0]             hit_idx, inv_idx;
  logic [EW-1:0]              new_ent;

  assign new_ent = {1'b1, AGE_W'(LIVE_TH), mac_q, pm_q};

  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (ram_we[w]) mem[w][ram_addr] <= ram_wd[w];
      else           ram_q[w]         <= mem[w][ram_addr];
    end
  end

  always_comb begin
    ram_addr = addr_q;
    ram_we   = '0;
    ram_wd   = '0;
    case (state_q)
      CLEAR: begin
        ram_addr = clr_q;
        ram_we   = '1;
      end
      IDLE: ram_addr = se_req ? se_hash : age_ptr_q;
      ACT: begin
        ram_we = act_we_q;
        for (int w = 0; w < WAYS; w++) ram_wd[w] = new_ent;
      end
      AG_WR: begin
        ram_we = '1;
        ram_wd = ag_wd_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    hit_d = '0;
    for (int w = 0; w < WAYS; w++)
      hit_d[w] = rd_q[w][EW-1] && (rd_q[w][MAC_HI:MAC_LO] == mac_q);
  end

  // Downward scans so the lowest-index way wins.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    inv_any = 1'b0;
    inv_idx = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_q[w]) begin
        hit_any = 1'b1;
        hit_idx = WIX'(w);
      end
      if (!rd_q[w][EW-1]) begin
        inv_any = 1'b1;
        inv_idx = WIX'(w);
      end
    end
  end

`ifdef HASH_EVICT_OLDEST_EN
  logic [WIX-1:0]   old_idx;
  logic [AGE_W-1:0] old_age;

  always_comb begin
    old_idx = '0;
    old_age = rd_q[0][AGE_HI:AGE_LO];
    for (int w = 1; w < WAYS; w++) begin
      if (rd_q[w][AGE_HI:AGE_LO] < old_age) begin
        old_age = rd_q[w][AGE_HI:AGE_LO];
        old_idx = WIX'(w);
      end
    end
  end
`endif

  always_comb begin
    act_ok_d = 1'b0;
    act_we_d = '0;
    res_d    = rd_q[hit_idx][PORT_W-1:0];
    if (!src_q) begin
      act_ok_d = hit_any;
    end else if (hit_any) begin
      act_ok_d          = 1'b1;
      act_we_d[hit_idx] = 1'b1;
    end else if (inv_any) begin
      act_ok_d          = 1'b1;
      act_we_d[inv_idx] = 1'b1;
    end
`ifdef HASH_EVICT_OLDEST_EN
    else begin
      act_ok_d          = 1'b1;
      act_we_d[old_idx] = 1'b1;
    end
`endif
  end

  always_comb begin
    ag_wd_d = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (rd_q[w][EW-1] && (rd_q[w][AGE_HI:AGE_LO] != '0)) begin
        ag_wd_d[w]                = rd_q[w];
        ag_wd_d[w][AGE_HI:AGE_LO] = rd_q[w][AGE_HI:AGE_LO] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= CLEAR;
      clr_q     <= '0;
      age_ptr_q <= '0;
      addr_q    <= '0;
      mac_q     <= '0;
      pm_q      <= '0;
      src_q     <= 1'b0;
      rd_q      <= '0;
      hit_q     <= '0;
      act_ok_q  <= 1'b0;
      act_we_q  <= '0;
      res_q     <= '0;
      ag_wd_q   <= '0;
      se_ack    <= 1'b0;
      se_nak    <= 1'b0;
      se_result <= '0;
      aging_ack <= 1'b0;
      init_done <= 1'b0;
    end else begin
      se_ack    <= 1'b0;
      se_nak    <= 1'b0;
      aging_ack <= 1'b0;
      case (state_q)
        CLEAR: begin
          clr_q <= clr_q + 1'b1;
          if (clr_q == '1) begin
            init_done <= 1'b1;
            state_q   <= IDLE;
          end
        end
        IDLE: begin
          if (se_req) begin
            mac_q   <= se_mac;
            pm_q    <= se_portmap;
            src_q   <= se_source;
            addr_q  <= se_hash;
            state_q <= RD;
          end else if (aging_req) begin
            addr_q    <= age_ptr_q;
            age_ptr_q <= age_ptr_q + 1'b1;
            aging_ack <= (age_ptr_q == '1);
            state_q   <= AG_WAIT;
          end
        end
        RD: begin
          rd_q    <= ram_q;
          state_q <= WAIT;
        end
        WAIT: begin
          hit_q   <= hit_d;
          state_q <= CMP;
        end
        CMP: begin
          act_ok_q <= act_ok_d;
          act_we_q <= act_we_d;
          res_q    <= res_d;
          state_q  <= ACT;
        end
        ACT: begin
          se_ack <= act_ok_q;
          se_nak <= !act_ok_q;
          if (!src_q && act_ok_q) se_result <= res_q;
          state_q <= DONE;
        end
        AG_WAIT: begin
          rd_q    <= ram_q;
          state_q <= AG_CMP;
        end
        AG_CMP: begin
          ag_wd_q <= ag_wd_d;
          state_q <= AG_WR;
        end
        AG_WR:   state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hash_nway_bucket.sv
// Scoreboard bench for hash_nway_bucket: default instance for search/evict/reset cases,
// a small instance (ADDR_W=4, LIVE_TH=2) for full aging passes.
module tb_hash_nway_bucket;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, sel, se_source, se_req, aging_req;
  logic [47:0] se_mac;
  logic [15:0] se_portmap;
  logic [9:0]  se_hash;
  logic        a_ack, a_nak, a_aack, a_init, b_ack, b_nak, b_aack, b_init;
  logic [15:0] a_res, b_res;
  logic        ack, nak, aack, init;
  logic [15:0] res;

  assign ack  = sel ? b_ack  : a_ack;
  assign nak  = sel ? b_nak  : a_nak;
  assign aack = sel ? b_aack : a_aack;
  assign init = sel ? b_init : a_init;
  assign res  = sel ? b_res  : a_res;

  hash_nway_bucket dut (
    .clk(clk), .rstn(rstn), .se_source(se_source), .se_mac(se_mac), .se_portmap(se_portmap),
    .se_hash(se_hash), .se_req(se_req && !sel), .se_ack(a_ack), .se_nak(a_nak), .se_result(a_res),
    .aging_req(aging_req && !sel), .aging_ack(a_aack), .init_done(a_init));

  hash_nway_bucket #(.ADDR_W(4), .LIVE_TH(2)) dut2 (
    .clk(clk), .rstn(rstn), .se_source(se_source), .se_mac(se_mac), .se_portmap(se_portmap),
    .se_hash(se_hash[3:0]), .se_req(se_req && sel), .se_ack(b_ack), .se_nak(b_nak), .se_result(b_res),
    .aging_req(aging_req && sel), .aging_ack(b_aack), .init_done(b_init));

  typedef struct {logic ok; logic [15:0] res; logic lkp;} exp_t;
  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [47:0] MAC_A = 48'h0011_2233_4455;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] mac_k(input int k);
    return 48'hA000_0000_0000 + 48'(k);
  endfunction

  // Waits for ack/nak of the request accepted in the current cycle, pops and compares.
  task automatic resp(input string tag, output logic saw_aack);
    int n;
    exp_t e;
    n = 0;
    saw_aack = 1'b0;
    do begin
      @(negedge clk);
      n++;
      saw_aack |= aack;
    end while (!(ack || nak) && n < 50);
    se_req = 1'b0;
    e = exp_q.pop_front();
    chk_val({tag, "/latency"}, 64'(n), 64'd5);
    chk_val({tag, "/ack"}, 64'(ack), 64'(e.ok));
    chk_val({tag, "/nak"}, 64'(nak), 64'(!e.ok));
    if (e.lkp && e.ok) chk_val({tag, "/result"}, 64'(res), 64'(e.res));
  endtask

  task automatic search(input string tag, input logic src, input logic [47:0] mac,
                        input logic [15:0] pm, input logic [9:0] hash,
                        input logic ok, input logic [15:0] rexp);
    logic s;
    @(negedge clk);
    se_source = src; se_mac = mac; se_portmap = pm; se_hash = hash; se_req = 1'b1;
    exp_q.push_back('{ok, rexp, !src});
    resp(tag, s);
  endtask

  task automatic age_steps(input int cnt, output int wraps, output logic last);
    wraps = 0;
    last  = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      aging_req = 1'b1;
      @(negedge clk);
      aging_req = 1'b0;
      last = aack;
      if (aack) wraps++;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic wait_init(input string tag, input int exp_n, output logic seen);
    int n;
    n = 0;
    seen = 1'b0;
    do begin
      @(negedge clk);
      n++;
      seen |= (ack || nak);
    end while (!init && n < 3000);
    chk_val({tag, "/clear_cycles"}, 64'(n), 64'(exp_n));
  endtask

  initial begin
    logic seen, last;
    logic [74:0] acc;
    int wraps;
    rstn = 1'b0; sel = 1'b0; se_req = 1'b0; aging_req = 1'b0;
    se_source = 1'b0; se_mac = '0; se_portmap = '0; se_hash = '0;
    repeat (2) @(negedge clk);
    chk_val("rst/init_done", 64'(a_init), 0);
    chk_val("rst/ack_nak", 64'({a_ack, a_nak, a_aack}), 0);
    chk_val("rst/result", 64'(a_res), 0);

    // Request held through CLEAR must wait for init_done.
    se_source = 1'b0; se_mac = MAC_A; se_hash = 10'h05A; se_req = 1'b1;
    exp_q.push_back('{1'b0, 16'h0, 1'b1});
    rstn = 1'b1;
    wait_init("clr", 1024, seen);
    chk_val("clr/no_resp_during_clear", 64'(seen), 0);
    resp("clr_req", seen);
    acc = '0;
    for (int w = 0; w < 4; w++)
      for (int a = 0; a < 1024; a++) acc |= dut.mem[w][a];
    chk_val("clr/ram_zero", 64'(acc), 0);

    search("learn_a", 1'b1, MAC_A, 16'h0004, 10'h05A, 1'b1, 16'h0);
    search("lookup_a", 1'b0, MAC_A, 16'h0, 10'h05A, 1'b1, 16'h0004);
    search("lookup_miss", 1'b0, MAC_A + 48'd1, 16'h0, 10'h05A, 1'b0, 16'h0);
    chk_val("miss/result_held", 64'(a_res), 64'h0004);
    search("refresh_a", 1'b1, MAC_A, 16'h0010, 10'h05A, 1'b1, 16'h0);
    chk_val("refresh/age", 64'(dut.mem[0][90][73:64]), 64'd150);
    chk_val("refresh/way1_unused", 64'(dut.mem[1][90][74]), 0);
    search("lookup_a2", 1'b0, MAC_A, 16'h0, 10'h05A, 1'b1, 16'h0010);

    for (int k = 0; k < 4; k++) begin
      search("fill", 1'b1, mac_k(k), 16'h0100 + 16'(k), 10'h3FF, 1'b1, 16'h0);
      chk_val("fill/way_mac", 64'(dut.mem[k][1023][63:16]), 64'(mac_k(k)));
    end

    // Walk the pointer up to set 0x3FF, then a search and an aging step arrive together.
    age_steps(1023, wraps, last);
    chk_val("age1023/wraps", 64'(wraps), 0);
    @(negedge clk);
    se_source = 1'b0; se_mac = mac_k(0); se_hash = 10'h3FF; se_req = 1'b1; aging_req = 1'b1;
    exp_q.push_back('{1'b1, 16'h0100, 1'b1});
    resp("prio_search", seen);
    chk_val("prio/no_aging_first", 64'(seen), 0);
    @(negedge clk);
    @(negedge clk);
    aging_req = 1'b0;
    chk_val("prio/aging_wrap_ack", 64'(aack), 1);
    repeat (3) @(negedge clk);

    search("refresh_m0", 1'b1, mac_k(0), 16'h0100, 10'h3FF, 1'b1, 16'h0);
    search("refresh_m1", 1'b1, mac_k(1), 16'h0101, 10'h3FF, 1'b1, 16'h0);
    search("refresh_m3", 1'b1, mac_k(3), 16'h0103, 10'h3FF, 1'b1, 16'h0);
    chk_val("aged/way2_age", 64'(dut.mem[2][1023][73:64]), 64'd149);
`ifdef HASH_EVICT_OLDEST_EN
    search("evict_learn", 1'b1, mac_k(4), 16'h0104, 10'h3FF, 1'b1, 16'h0);
    chk_val("evict/way2_mac", 64'(dut.mem[2][1023][63:16]), 64'(mac_k(4)));
    search("evict_old_gone", 1'b0, mac_k(2), 16'h0, 10'h3FF, 1'b0, 16'h0);
    search("evict_new_found", 1'b0, mac_k(4), 16'h0, 10'h3FF, 1'b1, 16'h0104);
`else
    search("full_learn", 1'b1, mac_k(4), 16'h0104, 10'h3FF, 1'b0, 16'h0);
    search("full_new_absent", 1'b0, mac_k(4), 16'h0, 10'h3FF, 1'b0, 16'h0);
    search("full_old_kept", 1'b0, mac_k(2), 16'h0, 10'h3FF, 1'b1, 16'h0102);
`endif
    search("full_m0_kept", 1'b0, mac_k(0), 16'h0, 10'h3FF, 1'b1, 16'h0100);

    // Reset during ACT aborts the lookup silently.
    @(negedge clk);
    se_source = 1'b0; se_mac = MAC_A; se_hash = 10'h05A; se_req = 1'b1;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    se_req = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= (ack || nak);
    end
    chk_val("rst_act/no_resp", 64'(seen), 0);
    chk_val("rst_act/init_low", 64'(a_init), 0);
    rstn = 1'b1;
    wait_init("rst_act", 1024, seen);
    search("post_rst_lookup", 1'b0, MAC_A, 16'h0, 10'h05A, 1'b0, 16'h0);

    // Small instance: LIVE_TH=2 entry survives two full passes, gone after the third.
    sel = 1'b1;
    chk_val("small/init_done", 64'(init), 1);
    search("small_learn", 1'b1, 48'h0000_CAFE_0001, 16'h0042, 10'h003, 1'b1, 16'h0);
    for (int p = 1; p <= 3; p++) begin
      age_steps(16, wraps, last);
      chk_val("small/pass_wraps", 64'(wraps), 1);
      chk_val("small/wrap_on_last", 64'(last), 1);
      search("small_lookup", 1'b0, 48'h0000_CAFE_0001, 16'h0, 10'h003, (p < 3), 16'h0042);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
